rx_buf: RTL and testbench
=========================

RX_BUF -- requirements
Module: rx_buf

Interface
REQ-001 Parameter DATA_W, default `PAYLOAD_SIZE+`ADDR_SZ, item width in bits (flit address plus payload).
REQ-002 Parameter LANES, default 1, number of serial lanes; legal values 1, 2, 4; DATA_W SHALL be a multiple of LANES.
REQ-003 Parameter DEPTH, default 4, output FIFO depth in items; power of two, at least 2.
REQ-004 Parameter PARITY, default 0; 1 adds an even-parity beat to every frame.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 serial_in  input  LANES  serial data lanes; lane 0 also carries the start bit and the parity bit.
REQ-008 item_read  input  1  consumer pops the head item; honoured only while valid is high.
REQ-009 valid  output  1  FIFO not empty; parallel_out holds the head item.
REQ-010 channel_busy  output  1  sender SHALL NOT start a frame while this is high.
REQ-011 parallel_out  output  DATA_W  FIFO head item; the value is don't-care when valid is low.
REQ-012 count  output  $clog2(DEPTH+1)  number of items held in the FIFO.
REQ-013 parity_err  output  1  one-cycle pulse; the frame just completed failed the parity check and was dropped.

Function
REQ-014 Frame format: start beat (serial_in[0]=1), then BEATS=DATA_W/LANES data beats, then one parity beat if PARITY=1.
REQ-015 Data beat j, lane k carries item bit j*LANES+k, so bits arrive LSB first.
REQ-016 Parity bit = XOR of all DATA_W item bits, sent on serial_in[0]; upper lanes are ignored in that beat.
REQ-017 Receiver FSM states:
- IDLE: go to RECV when serial_in[0]=1 and the FIFO is not full; the beat counter clears to 0.
- RECV: one beat captured per cycle; after beat BEATS-1, go to PAR if PARITY=1, else to IDLE.
- PAR: check the parity bit, then go to IDLE.
REQ-018 In IDLE, serial_in is ignored when serial_in[0]=0 or the FIFO is full; no frame starts.
REQ-019 Completion with PARITY=0: the item is written on the edge that samples the last data beat.
REQ-020 Completion with PARITY=1: the item is written on the edge that samples the parity beat, if parity matches; otherwise nothing is written and parity_err is high for the following cycle.
REQ-021 Item latency: valid and count reflect the write in the cycle after the completing edge.
REQ-022 A new start bit SHALL be accepted in the first IDLE cycle after a frame completes; no gap cycle is required.
REQ-023 channel_busy = (state != IDLE) | (count == DEPTH), combinational.
REQ-024 Pop: item_read & valid advances the read pointer on the edge; item_read with valid low is ignored and has no side effect.
REQ-025 A simultaneous write and pop SHALL leave count unchanged and keep FIFO order intact.
REQ-026 A write cannot target a full FIFO, because frames start only when not full; the implementation SHALL still block any write while count == DEPTH.
REQ-027 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; full and empty are decided from count.
REQ-028 parallel_out SHALL be driven from FIFO storage indexed by the read pointer, with no extra register stage.

Reset
REQ-029 On reset the FSM SHALL go to IDLE and clear the beat counter, both pointers, count and the shift register.
REQ-030 After reset: valid=0, channel_busy=0, count=0, parity_err=0; parallel_out is don't-care.
REQ-031 Reset asserted mid-frame or mid-check SHALL discard the partial frame; no write and no parity_err follow.

Verification (DATA_W=8, LANES=2, DEPTH=2, PARITY=1 unless stated)
REQ-032 Single frame 0xA5: serial_in sequence 01 (start), 01, 01, 10, 10, parity 0 -> channel_busy high for cycles 1-5; valid=1, parallel_out=0xA5, count=1 from cycle 6.
REQ-033 Same frame with parity bit 1 -> parity_err pulses for exactly one cycle; valid stays 0; count stays 0; channel_busy drops.
REQ-034 Two frames 0x3C and 0xC3 back to back, no pops -> count=2, channel_busy stays high; a third start bit is ignored; item_read pops 0x3C, then 0xC3; channel_busy falls in the cycle after the first pop.
REQ-035 A pop coinciding with the completing edge of a second frame (count=1) -> count stays 1 and parallel_out shows the second item.
REQ-036 Reset asserted after data beat 2, then a full frame 0x5A -> no write for the aborted frame; 0x5A is received intact.
REQ-037 LANES=1, PARITY=0, DATA_W=8, DEPTH=4: frame 0x81 -> valid rises 9 cycles after the start beat; 5 frames with no pops leave count=4, and wrap-around ordering is preserved across 6 pushes and pops.

Source files
------------

// File: rtl/rx_buf.sv
// Serial-to-parallel frame receiver feeding a small output FIFO.
// Frames are a start beat, BEATS data beats (LSB first across lanes) and an optional parity beat.

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 32
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module rx_buf #(
  parameter int DATA_W = `PAYLOAD_SIZE + `ADDR_SZ,
  parameter int LANES  = 1,
  parameter int DEPTH  = 4,
  parameter int PARITY = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES-1:0]             serial_in,
  input  logic                         item_read,
  output logic                         valid,
  output logic                         channel_busy,
  output logic [DATA_W-1:0]            parallel_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         parity_err
);

  localparam int BEATS = DATA_W / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;

  state_t              state, state_next;
  logic [BW-1:0]       beat, beat_next;
  logic [DATA_W-1:0]   shreg, shreg_next;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_req;
  logic                perr_next;
  logic                full, empty, wr_en, rd_en;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // Each beat enters at the top, so after BEATS shifts beat 0 sits in the LSBs.
  assign shifted = {serial_in, shreg[DATA_W-1:LANES]};

  always_comb begin
    state_next = state;
    beat_next  = beat;
    shreg_next = shreg;
    wr_req     = 1'b0;
    wr_data    = shifted;
    perr_next  = 1'b0;
    case (state)
      IDLE: begin
        if (serial_in[0] && !full) begin
          state_next = RECV;
          beat_next  = '0;
        end
      end
      RECV: begin
        shreg_next = shifted;
        beat_next  = beat + BW'(1);
        if (beat == LAST_BEAT) begin
          beat_next = '0;
          if (PARITY != 0) begin
            state_next = PAR;
          end else begin
            state_next = IDLE;
            wr_req     = 1'b1;
          end
        end
      end
      PAR: begin
        state_next = IDLE;
        wr_data    = shreg;
        if ((^shreg) == serial_in[0]) wr_req = 1'b1;
        else                          perr_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      beat       <= '0;
      shreg      <= '0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_next;
      beat       <= beat_next;
      shreg      <= shreg_next;
      parity_err <= perr_next;
    end
  end

  // Writes are gated by full even though the FSM never starts a frame while full.
  assign wr_en = wr_req & ~full;
  assign rd_en = item_read & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign parallel_out = mem[rd_ptr];
  assign valid        = ~empty;
  assign channel_busy = (state != IDLE) | full;

endmodule

// File: tb/tb_rx_buf.sv
// Scoreboard bench for rx_buf: a 2-lane parity configuration and a 1-lane no-parity configuration.

module tb_rx_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [1:0] si_a;
  logic [0:0] si_b;
  logic       rd_a, rd_b;
  logic       valid_a, busy_a, perr_a;
  logic       valid_b, busy_b, perr_b;
  logic [7:0] out_a, out_b;
  logic [1:0] cnt_a;
  logic [2:0] cnt_b;

  rx_buf #(.DATA_W(8), .LANES(2), .DEPTH(2), .PARITY(1)) dut_a (
    .clk(clk), .reset(rst_a), .serial_in(si_a), .item_read(rd_a),
    .valid(valid_a), .channel_busy(busy_a), .parallel_out(out_a),
    .count(cnt_a), .parity_err(perr_a)
  );

  rx_buf #(.DATA_W(8), .LANES(1), .DEPTH(4), .PARITY(0)) dut_b (
    .clk(clk), .reset(rst_b), .serial_in(si_b), .item_read(rd_b),
    .valid(valid_b), .channel_busy(busy_b), .parallel_out(out_b),
    .count(cnt_b), .parity_err(perr_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: a pop happens on the next edge, so compare the head now.
  always @(negedge clk) begin
    if (rd_a && valid_a) begin
      if (qa.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pop_a: got %0h expected nothing", out_a);
      end else begin
        $display("pop_a item %02h (expected %02h)", out_a, qa[0]);
        chk("pop_a", out_a, qa.pop_front());
      end
    end
    if (rd_b && valid_b) begin
      if (qb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pop_b: got %0h expected nothing", out_b);
      end else begin
        $display("pop_b item %02h (expected %02h)", out_b, qb[0]);
        chk("pop_b", out_b, qb.pop_front());
      end
    end
  end

  task automatic a_frame(input logic [7:0] d, input bit bad, input bit pop_last, input bit chkb);
    if (chkb) chk("busy_a_start", busy_a, 0);
    si_a = 2'b01;
    tick();
    for (int j = 0; j < 4; j++) begin
      si_a = d[2*j +: 2];
      if (chkb) chk("busy_a_beat", busy_a, 1);
      tick();
    end
    si_a = {1'b0, (^d) ^ bad};
    rd_a = pop_last;
    if (chkb) chk("busy_a_par", busy_a, 1);
    tick();
    si_a = 2'b00;
    rd_a = 1'b0;
    if (!bad) qa.push_back(d);
    $display("frame_a %02h bad=%0d", d, bad);
  endtask

  task automatic b_frame(input logic [7:0] d, input bit push, input bit chk_lat);
    si_b = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      si_b = d[j];
      if (chk_lat && j == 7) chk("lat_b_before", valid_b, 0);
      tick();
    end
    si_b = 1'b0;
    if (chk_lat) chk("lat_b_after", valid_b, 1);
    if (push) qb.push_back(d);
    $display("frame_b %02h push=%0d", d, push);
  endtask

  task automatic pop_a();
    rd_a = 1'b1;
    tick();
    rd_a = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    si_a = '0; si_b = '0; rd_a = 1'b0; rd_b = 1'b0;
    repeat (2) tick();
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    chk("rst_valid_a", valid_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_count_a", cnt_a, 0);
    chk("rst_perr_a", perr_a, 0);
    chk("rst_valid_b", valid_b, 0);
    chk("rst_count_b", cnt_b, 0);

    // Single good frame
    a_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    chk("a5_valid", valid_a, 1);
    chk("a5_count", cnt_a, 1);
    chk("a5_data", out_a, 8'hA5);
    pop_a();
    chk("a5_count_pop", cnt_a, 0);

    // Bad parity: dropped with a one-cycle error pulse
    a_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    chk("perr_pulse", perr_a, 1);
    chk("perr_valid", valid_a, 0);
    chk("perr_count", cnt_a, 0);
    chk("perr_busy", busy_a, 0);
    rd_a = 1'b1;
    tick();
    rd_a = 1'b0;
    chk("perr_clear", perr_a, 0);
    chk("empty_pop_count", cnt_a, 0);

    // Back-to-back frames fill the FIFO; a third start is ignored
    a_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    a_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    chk("full_count", cnt_a, 2);
    chk("full_busy", busy_a, 1);
    si_a = 2'b01;
    tick();
    si_a = 2'b11;
    repeat (6) tick();
    si_a = 2'b00;
    chk("full_ignore_count", cnt_a, 2);
    chk("full_ignore_busy", busy_a, 1);
    pop_a();
    chk("after_pop_busy", busy_a, 0);
    chk("after_pop_count", cnt_a, 1);
    pop_a();
    chk("drain_count", cnt_a, 0);

    // Pop coinciding with the completing edge of a second frame
    a_frame(8'h11, 1'b0, 1'b0, 1'b0);
    a_frame(8'h22, 1'b0, 1'b1, 1'b0);
    chk("wrpop_count", cnt_a, 1);
    chk("wrpop_data", out_a, 8'h22);
    pop_a();

    // Reset in the middle of a frame
    si_a = 2'b01; tick();
    si_a = 2'b11; tick();
    si_a = 2'b01; tick();
    #2 rst_a = 1'b1;
    #2 rst_a = 1'b0;
    si_a = 2'b00;
    tick();
    tick();
    chk("abort_count", cnt_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_perr", perr_a, 0);
    a_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("after_abort_count", cnt_a, 1);
    chk("after_abort_data", out_a, 8'h5A);
    pop_a();

    // Single-lane, no-parity configuration
    b_frame(8'h81, 1'b1, 1'b1);
    chk("b81_data", out_b, 8'h81);
    rd_b = 1'b1; tick(); rd_b = 1'b0;
    b_frame(8'h01, 1'b1, 1'b0);
    b_frame(8'h02, 1'b1, 1'b0);
    b_frame(8'h04, 1'b1, 1'b0);
    b_frame(8'h08, 1'b1, 1'b0);
    b_frame(8'hF0, 1'b0, 1'b0);
    chk("b_full_count", cnt_b, 4);
    chk("b_full_busy", busy_b, 1);
    rd_b = 1'b1; repeat (2) tick(); rd_b = 1'b0;
    chk("b_half_count", cnt_b, 2);
    b_frame(8'h10, 1'b1, 1'b0);
    b_frame(8'h20, 1'b1, 1'b0);
    chk("b_wrap_count", cnt_b, 4);
    rd_b = 1'b1; repeat (4) tick(); rd_b = 1'b0;
    chk("b_drain_count", cnt_b, 0);
    chk("b_drain_valid", valid_b, 0);
    chk("b_perr", perr_b, 0);

    tick();
    chk("qa_left", qa.size(), 0);
    chk("qb_left", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
